// File: rtl/reaction_round_controller_pkg.sv
// Shared definitions for the reaction-round controller: FSM encoding, counter widths
// and the LFSR step function.
`ifndef REACTION_ROUND_CONTROLLER_PKG_SV
`define REACTION_ROUND_CONTROLLER_PKG_SV
package reaction_round_controller_pkg;

  localparam int DELAY_W = 11;
  localparam int COUNT_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_t;

  // Fibonacci form of x^8+x^6+x^5+x^4+1; maximal length, so a nonzero seed never hits zero.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage
`endif

// File: rtl/reaction_round_controller_lfsr8.sv
// Free-running 8-bit LFSR that supplies the random part of the pre-GO delay.
module lfsr8
  import reaction_round_controller_pkg::*;
(
  input  logic       ClockIn,
  input  logic       CLRN,
  output logic [7:0] out
);

  logic [7:0] r_state;

  always_ff @(posedge ClockIn or negedge CLRN) begin
    if (!CLRN) r_state <= 8'h01;
    else       r_state <= lfsr8_step(r_state);
  end

  assign out = r_state;

endmodule

// File: rtl/reaction_round_controller.sv
// Reaction-time game round controller: randomized wait, GO window with a
// saturating reaction counter, foul and timeout detection.
module reaction_round_controller
  import reaction_round_controller_pkg::*;
#(
  parameter logic [DELAY_W-1:0] MIN_DELAY = 11'd500,
  parameter logic [COUNT_W-1:0] TIMEOUT   = 13'd8191
)(
  input  logic               ClockIn,
  input  logic               CLRN,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Button,
  output logic               GoLed,
  output logic [COUNT_W-1:0] Result,
  output logic               ResultValid,
  output logic               Foul,
  output logic               TimedOut,
  output logic               Busy
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           w_lfsr;
  logic [DELAY_W-1:0]   w_delay_load;
  logic [DELAY_W-1:0]   r_delay;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   r_result;
  logic                 r_result_vld;
  logic                 r_foul;
  logic                 r_timed_out;

  lfsr8 u_lfsr8 (
    .ClockIn (ClockIn),
    .CLRN    (CLRN),
    .out     (w_lfsr)
  );

  // LFSR scaled by 4 keeps the sum inside 11 bits for any 11-bit MIN_DELAY up to 1027.
  assign w_delay_load = MIN_DELAY + {1'b0, w_lfsr, 2'b00};

  always_ff @(posedge ClockIn or negedge CLRN) begin
    if (!CLRN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (Start) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (Button)                                 w_state_nxt = ST_FOUL;
        else if (Tick && (r_delay <= DELAY_W'(1)))  w_state_nxt = ST_GO;
      end
      ST_GO: begin
        if (Button || (r_count >= TIMEOUT)) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ClockIn or negedge CLRN) begin
    if (!CLRN) begin
      r_delay      <= '0;
      r_count      <= '0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_foul       <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_result_vld <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_FOUL: begin
          if (Start) begin
            r_delay     <= w_delay_load;
            r_count     <= '0;
            r_foul      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (Button)                          r_foul  <= 1'b1;
          else if (Tick && (r_delay != '0))    r_delay <= r_delay - DELAY_W'(1);
        end
        ST_GO: begin
          // A press in the same cycle as the timeout is a genuine result.
          if (Button) begin
            r_result     <= r_count;
            r_result_vld <= 1'b1;
          end else if (r_count >= TIMEOUT) begin
            r_result     <= TIMEOUT;
            r_result_vld <= 1'b1;
            r_timed_out  <= 1'b1;
          end else if (Tick) begin
            r_count <= r_count + COUNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign GoLed       = (r_state == ST_GO);
  assign Busy        = (r_state == ST_WAIT) || (r_state == ST_GO);
  assign Result      = r_result;
  assign ResultValid = r_result_vld;
  assign Foul        = r_foul;
  assign TimedOut    = r_timed_out;

endmodule

// File: tb/tb_reaction_round_controller.sv
// Randomized round-level bench for reaction_round_controller with a transaction model.
module tb_reaction_round_controller;

  localparam int MIN_D = 4;
  localparam int TO    = 20;

  logic        ClockIn = 1'b0;
  logic        CLRN;
  logic        Tick;
  logic        Start;
  logic        Button;
  logic        GoLed;
  logic [12:0] Result;
  logic        ResultValid;
  logic        Foul;
  logic        TimedOut;
  logic        Busy;

  int          vec_cnt     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          exp_res     = 0;
  logic [7:0]  lfsr_m      = 8'h01;

  reaction_round_controller #(
    .MIN_DELAY (11'(MIN_D)),
    .TIMEOUT   (13'(TO))
  ) dut (
    .ClockIn     (ClockIn),
    .CLRN        (CLRN),
    .Tick        (Tick),
    .Start       (Start),
    .Button      (Button),
    .GoLed       (GoLed),
    .Result      (Result),
    .ResultValid (ResultValid),
    .Foul        (Foul),
    .TimedOut    (TimedOut),
    .Busy        (Busy)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Polynomial taps 8,6,5,4 written as a parity mask over the register.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  function automatic bit next_tick();
    return (cyc % 4) == 3;
  endfunction

  // Drive one clock's inputs, advance past the rising edge, and track the LFSR.
  task automatic step(input bit s, input bit b);
    Start  = s;
    Button = b;
    Tick   = next_tick();
    @(posedge ClockIn);
    #1;
    if (CLRN) lfsr_m = lfsr_next(lfsr_m);
    cyc++;
  endtask

  task automatic async_reset();
    #2 CLRN = 1'b0;
    #1;
    chk("rst_goled", 32'(GoLed),       32'd0);
    chk("rst_busy",  32'(Busy),        32'd0);
    chk("rst_res",   32'(Result),      32'd0);
    chk("rst_vld",   32'(ResultValid), 32'd0);
    chk("rst_foul",  32'(Foul),        32'd0);
    chk("rst_to",    32'(TimedOut),    32'd0);
    lfsr_m  = 8'h01;
    exp_res = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_hold_busy", 32'(Busy), 32'd0);
    #2 CLRN = 1'b1;
  endtask

  // mode: 0 press after k GO ticks, 1 foul after j WAIT ticks, 2 foul on final WAIT tick,
  //       3 timeout (pto: press in the timeout cycle), 4 reset mid-GO, 5 reset mid-WAIT
  task automatic do_round(input int mode, input int karg, input bit spam, input bit pto);
    int d, j, ticks, cnt;
    bit t, b, s, fouled, done;
    d = MIN_D + 4 * int'(lfsr_m);
    step(1'b1, 1'b0);
    chk("start_busy",  32'(Busy),     32'd1);
    chk("start_goled", 32'(GoLed),    32'd0);
    chk("start_foul",  32'(Foul),     32'd0);
    chk("start_to",    32'(TimedOut), 32'd0);
    chk("start_res",   32'(Result),   32'(exp_res));
    j = karg % d;
    ticks = 0;
    fouled = 1'b0;
    while (ticks < d && !fouled) begin
      t = next_tick();
      if (mode == 5 && ticks == j) begin
        async_reset();
        return;
      end
      b = (mode == 1 && ticks == j) || (mode == 2 && t && ticks == d - 1);
      s = spam && ($urandom_range(0, 5) == 0) && !b;
      step(s, b);
      if (b) fouled = 1'b1;
      else if (t) ticks++;
      if (!fouled && ticks < d) begin
        chk("wait_goled", 32'(GoLed), 32'd0);
        chk("wait_busy",  32'(Busy),  32'd1);
      end
    end
    if (fouled) begin
      chk("foul_flag",  32'(Foul),        32'd1);
      chk("foul_goled", 32'(GoLed),       32'd0);
      chk("foul_busy",  32'(Busy),        32'd0);
      chk("foul_vld",   32'(ResultValid), 32'd0);
      chk("foul_res",   32'(Result),      32'(exp_res));
      step(1'b0, 1'b0);
      chk("foul_hold",     32'(Foul),        32'd1);
      chk("foul_hold_vld", 32'(ResultValid), 32'd0);
      chk("foul_hold_go",  32'(GoLed),       32'd0);
      return;
    end
    chk("go_entry", 32'(GoLed), 32'd1);
    cnt = 0;
    done = 1'b0;
    while (!done) begin
      t = next_tick();
      if (mode == 4 && cnt == karg % TO) begin
        async_reset();
        return;
      end
      b = (mode == 0 && cnt == karg % TO) || (mode == 3 && pto && cnt == TO);
      s = spam && ($urandom_range(0, 5) == 0) && !b;
      step(s, b);
      if (b || cnt == TO) begin
        exp_res = cnt;
        done = 1'b1;
        chk("done_vld",   32'(ResultValid), 32'd1);
        chk("done_res",   32'(Result),      32'(exp_res));
        chk("done_to",    32'(TimedOut),    b ? 32'd0 : 32'd1);
        chk("done_goled", 32'(GoLed),       32'd0);
        chk("done_busy",  32'(Busy),        32'd0);
        chk("done_foul",  32'(Foul),        32'd0);
      end else begin
        if (t) cnt++;
        chk("go_goled", 32'(GoLed),       32'd1);
        chk("go_busy",  32'(Busy),        32'd1);
        chk("go_vld",   32'(ResultValid), 32'd0);
      end
    end
    step(1'b0, 1'b0);
    chk("hold_vld", 32'(ResultValid), 32'd0);
    chk("hold_res", 32'(Result),      32'(exp_res));
    chk("hold_to",  32'(TimedOut),    (cnt == TO && !(mode == 3 && pto)) ? 32'd1 : 32'd0);
  endtask

  initial begin
    CLRN   = 1'b0;
    Start  = 1'b0;
    Button = 1'b0;
    Tick   = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    chk("por_goled", 32'(GoLed),       32'd0);
    chk("por_busy",  32'(Busy),        32'd0);
    chk("por_res",   32'(Result),      32'd0);
    chk("por_vld",   32'(ResultValid), 32'd0);
    chk("por_foul",  32'(Foul),        32'd0);
    chk("por_to",    32'(TimedOut),    32'd0);
    #2 CLRN = 1'b1;

    do_round(0, 5, 1'b0, 1'b0);   // first Start after reset: delay 8, press after 5 ticks
    do_round(1, 3, 1'b0, 1'b0);   // early press
    do_round(3, 0, 1'b0, 1'b0);   // timeout
    do_round(2, 0, 1'b0, 1'b0);   // press on the final WAIT tick
    do_round(3, 0, 1'b0, 1'b1);   // press in the timeout cycle
    for (int r = 0; r < 8; r++)
      do_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), 1'b1,
               1'($urandom_range(0, 1)));
    do_round(4, 6, 1'b1, 1'b0);   // reset mid-GO
    do_round(0, 2, 1'b0, 1'b0);   // behaves as from power-up
    do_round(5, 2, 1'b0, 1'b0);   // reset mid-WAIT
    do_round(0, 19, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_round_controller.md
REACTION_ROUND_CONTROLLER -- requirements
Module: reaction_round_controller

Interface
REQ-001 Parameter MIN_DELAY, default 11'd500: minimum pre-GO wait, in Tick periods.
REQ-002 Parameter TIMEOUT, default 13'd8191: reaction count at which a round ends without a press.
REQ-003 ClockIn  input  1  sole clock; all state changes on rising edge.
REQ-004 CLRN  input  1  reset, asynchronous, active-low.
REQ-005 Tick  input  1  one-cycle enable strobe, 1 ms period; all delay and reaction counting advances only on Tick.
REQ-006 Start  input  1  synchronous, debounced round request.
REQ-007 Button  input  1  synchronous, debounced player press; level-sensitive.
REQ-008 GoLed  output  1  high while the player should react.
REQ-009 Result  output  13  last reaction time in Ticks; holds until the next round's result.
REQ-010 ResultValid  output  1  one-cycle pulse when Result updates.
REQ-011 Foul  output  1  high from an early press until the next Start.
REQ-012 TimedOut  output  1  high from a timeout until the next Start.
REQ-013 Busy  output  1  high in WAIT and GO.

Function
REQ-014 States SHALL be IDLE, WAIT, GO, DONE, FOUL; encoding fixed in the shared header.
REQ-015 An 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every clock and SHALL never reach zero.
REQ-016 Start=1 in IDLE, DONE or FOUL SHALL enter WAIT, load an 11-bit delay = MIN_DELAY + {LFSR,2'b00}, clear Foul and TimedOut, and clear the reaction count.
REQ-017 Start SHALL be ignored in WAIT and GO.
REQ-018 In WAIT the delay SHALL decrement by one per Tick; on the Tick that brings it to zero the FSM SHALL enter GO on the next edge.
REQ-019 Button=1 in WAIT SHALL enter FOUL and set Foul; if Button and delay expiry coincide, FOUL SHALL win.
REQ-020 In GO, GoLed=1, and the 13-bit reaction count SHALL increment by one per Tick, starting from 0 on GO entry.
REQ-021 Button=1 in GO SHALL load Result with the current count, pulse ResultValid, and enter DONE.
REQ-022 When the count reaches TIMEOUT in GO, the FSM SHALL load Result=TIMEOUT, pulse ResultValid, set TimedOut, and enter DONE; Button in that same cycle SHALL take precedence (normal result, TimedOut=0).
REQ-023 The count SHALL never wrap; it saturates at TIMEOUT.
REQ-024 GoLed SHALL be 0 in every state except GO; Busy SHALL be 1 only in WAIT or GO.
REQ-025 Result, Foul and TimedOut SHALL hold in DONE/FOUL until the next accepted Start (Result persists beyond Start).

Reset
REQ-026 CLRN=0 SHALL immediately force: state IDLE, LFSR 8'h01, delay 0, count 0, Result 0, and all 1-bit outputs 0, regardless of the current state (including mid-WAIT and mid-GO).
REQ-027 After CLRN deasserts, the first accepted Start SHALL behave as from power-up.

Structure
REQ-028 State encodings, DELAY_W=11 and COUNT_W=13 SHALL live in a shared `include header guarded by `ifndef.
REQ-029 The LFSR SHALL be a separate sub-module lfsr8 (ports ClockIn, CLRN, out[7:0]); counters and FSM remain in this module.

Verification (MIN_DELAY=4, TIMEOUT=20, Tick every 4 clocks)
REQ-030 Reset, Start on the first clock after reset (LFSR=8'h01): delay=8; after 8 Ticks GoLed=1; Button after 5 Ticks in GO -> Result=5, ResultValid one cycle, DONE.
REQ-031 Button during WAIT -> Foul=1, GoLed never asserts, Result unchanged, ResultValid never pulses.
REQ-032 No Button in GO -> after 20 Ticks Result=20, TimedOut=1, count does not pass 20.
REQ-033 Button on the final WAIT Tick -> FOUL, not GO; Button on the TIMEOUT Tick -> TimedOut=0, Result=20.
REQ-034 CLRN pulse mid-GO -> GoLed=0, Busy=0, Result=0 asynchronously, before the next clock edge.
REQ-035 Start asserted in WAIT or GO -> no state change, delay and count unaffected.
